// File: rtl/bellman_ford_sequencer_pkg.sv
// ============================================================================
// bf_pkg : shared types and widths for the Bellman-Ford sequencer slice
// Rev 1.0
// ============================================================================
`default_nettype none

package bf_pkg;

  localparam int VADDR_W = 5;
  localparam int LANES   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ITER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bf_state_e;

endpackage

`default_nettype wire

// File: rtl/bellman_ford_sequencer_if.sv
// ============================================================================
// bellman_ford_sequencer_if : host, datapath and readout signals of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface bellman_ford_sequencer_if;
  import bf_pkg::*;

  logic               start;
  logic [VADDR_W-1:0] src_vertex;
  logic [LANES-1:0]   relax_wr;
  logic               dp_clear;
  logic               dp_enable;
  logic               stg1_mux_control;
  logic [VADDR_W-1:0] source_address;
  logic [VADDR_W-1:0] predecessor_rd_addr;
  logic [VADDR_W-1:0] predecessor_in;
  logic               busy;
  logic               done;
  logic [VADDR_W-1:0] iter_count;
  logic               rd_req;
  logic [VADDR_W-1:0] rd_vertex;
  logic               rd_ready;
  logic               rd_valid;
  logic [VADDR_W-1:0] rd_pred;

  // Environment side: host plus datapath stand-in.
  modport master (
    output start, src_vertex, relax_wr, predecessor_in, rd_req, rd_vertex,
    input  dp_clear, dp_enable, stg1_mux_control, source_address,
           predecessor_rd_addr, busy, done, iter_count, rd_ready, rd_valid, rd_pred
  );

  // Sequencer side.
  modport slave (
    input  start, src_vertex, relax_wr, predecessor_in, rd_req, rd_vertex,
    output dp_clear, dp_enable, stg1_mux_control, source_address,
           predecessor_rd_addr, busy, done, iter_count, rd_ready, rd_valid, rd_pred
  );

endinterface

`default_nettype wire

// File: rtl/bellman_ford_sequencer_readout.sv
// ============================================================================
// bf_readout_port : single-outstanding predecessor readout with READ_LAT delay
// Rev 1.0
// ============================================================================
`default_nettype none

module bf_readout_port
  import bf_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en_i,
  input  logic               cancel_i,
  input  logic               rd_req_i,
  input  logic [VADDR_W-1:0] rd_vertex_i,
  input  logic [VADDR_W-1:0] pred_in_i,
  output logic               rd_ready_o,
  output logic               rd_valid_o,
  output logic [VADDR_W-1:0] rd_pred_o,
  output logic [VADDR_W-1:0] rd_addr_o
);

  logic [READ_LAT-1:0] pipe_q, pipe_d;
  logic [VADDR_W-1:0]  addr_q, addr_d;
  logic [VADDR_W-1:0]  pred_q, pred_d;
  logic                valid_q, valid_d;
  logic                accept;

  // A start in DONE takes priority over a same-cycle request.
  assign rd_ready_o = en_i & ~(|pipe_q) & ~cancel_i;
  assign accept     = rd_req_i & rd_ready_o;

  always_comb begin
    pipe_d  = (pipe_q << 1) | READ_LAT'(accept);
    addr_d  = accept ? rd_vertex_i : addr_q;
    valid_d = pipe_q[READ_LAT-1] & en_i & ~cancel_i;
    pred_d  = valid_d ? pred_in_i : pred_q;
    if (!en_i || cancel_i) begin
      pipe_d = '0;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pipe_q  <= '0;
      addr_q  <= '0;
      pred_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      addr_q  <= addr_d;
      pred_q  <= pred_d;
      valid_q <= valid_d;
    end
  end

  assign rd_valid_o = valid_q;
  assign rd_pred_o  = pred_q;
  assign rd_addr_o  = addr_q;

endmodule

`default_nettype wire

// File: rtl/bellman_ford_sequencer.sv
// ============================================================================
// bellman_ford_sequencer : run control for the pipelined Bellman-Ford datapath
// Rev 1.0  -- optional early termination: define BF_EARLY_EXIT_EN
// ============================================================================
`default_nettype none

module bellman_ford_sequencer
  import bf_pkg::*;
#(
  parameter int NUM_VERTICES = 32,
  parameter int EDGE_BEATS   = 8,
  parameter int PIPE_DEPTH   = 4,
  parameter int READ_LAT     = 1
) (
  input logic clk,
  input logic clear,
  bellman_ford_sequencer_if.slave bus
);

  localparam int CNT_MAX = (EDGE_BEATS > PIPE_DEPTH) ? EDGE_BEATS : PIPE_DEPTH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(EDGE_BEATS - 1);
  localparam logic [CNT_W-1:0]   LAST_DRAIN = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [VADDR_W-1:0] ITER_LAST  = VADDR_W'(NUM_VERTICES - 1);

  bf_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VADDR_W-1:0] iter_q, iter_d, iter_inc;
  logic [VADDR_W-1:0] src_q, src_d;
  logic               start_acc;
  logic               early_stop;
  logic               in_done;

  assign iter_inc = (iter_q == ITER_LAST) ? iter_q : iter_q + VADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iter_d    = iter_q;
    src_d     = src_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: start_acc = bus.start;
      INIT: begin
        iter_d  = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          cnt_d   = '0;
          iter_d  = iter_inc;
          state_d = (iter_inc == ITER_LAST || early_stop) ? DONE : ITER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    start_acc = bus.start;
      default: state_d = IDLE;
    endcase
    if (start_acc) begin
      src_d   = bus.src_vertex;
      state_d = INIT;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      src_q   <= src_d;
    end
  end

`ifdef BF_EARLY_EXIT_EN
  logic relax_seen_q, relax_seen_d;
  logic relax_any;

  assign relax_any  = |bus.relax_wr;
  // The final DRAIN cycle's own write enables count toward the decision.
  assign early_stop = ~(relax_seen_q | relax_any);

  always_comb begin
    relax_seen_d = relax_seen_q;
    if (state_d == ITER && state_q != ITER) begin
      relax_seen_d = 1'b0;
    end else if (state_q == ITER || state_q == DRAIN) begin
      relax_seen_d = relax_seen_q | relax_any;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      relax_seen_q <= 1'b0;
    end else begin
      relax_seen_q <= relax_seen_d;
    end
  end
`else
  assign early_stop = 1'b0;
`endif

  assign in_done = (state_q == DONE);

  assign bus.dp_clear         = (state_q == INIT);
  assign bus.dp_enable        = (state_q == ITER);
  assign bus.stg1_mux_control = in_done;
  assign bus.done             = in_done;
  assign bus.busy             = (state_q == INIT) || (state_q == ITER) || (state_q == DRAIN);
  assign bus.source_address   = src_q;
  assign bus.iter_count       = iter_q;

  bf_readout_port #(
    .READ_LAT (READ_LAT)
  ) u_readout (
    .clk         (clk),
    .clear       (clear),
    .en_i        (in_done),
    .cancel_i    (start_acc),
    .rd_req_i    (bus.rd_req),
    .rd_vertex_i (bus.rd_vertex),
    .pred_in_i   (bus.predecessor_in),
    .rd_ready_o  (bus.rd_ready),
    .rd_valid_o  (bus.rd_valid),
    .rd_pred_o   (bus.rd_pred),
    .rd_addr_o   (bus.predecessor_rd_addr)
  );

endmodule

`default_nettype wire

// File: tb/tb_bellman_ford_sequencer.sv
// ============================================================================
// tb_bellman_ford_sequencer : scoreboard bench for bellman_ford_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bellman_ford_sequencer;
  import bf_pkg::*;

  localparam int NV = 32;
  localparam int EB = 8;
  localparam int PD = 4;
  localparam int RL = 1;

  localparam int K_DONE = 0;
  localparam int K_READ = 1;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic zero_iter3 = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sbq[$];

  bellman_ford_sequencer_if bus();

  bellman_ford_sequencer #(
    .NUM_VERTICES (NV),
    .EDGE_BEATS   (EB),
    .PIPE_DEPTH   (PD),
    .READ_LAT     (RL)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: pred(v) = (7*v + 3) mod 32, combinational read.
  assign bus.predecessor_in = bus.predecessor_rd_addr * 5'd7 + 5'd3;
  assign bus.relax_wr = (zero_iter3 && bus.busy && bus.iter_count == 5'd2) ? 4'h0 : 4'hF;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with no matching expectation (cycle %0d)", name, cyc);
  endtask

  task automatic push_exp(input int kind, input int a, input int b, input int c);
    exp_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    e.c = c;
    sbq.push_back(e);
  endtask

  function automatic int out_vec();
    return 32'({bus.dp_clear, bus.dp_enable, bus.stg1_mux_control, bus.source_address,
                bus.predecessor_rd_addr, bus.busy, bus.done, bus.iter_count,
                bus.rd_ready, bus.rd_valid, bus.rd_pred});
  endfunction

  task automatic wait_done(input int limit);
    int n = 0;
    while (!bus.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", int'(bus.done), 1);
  endtask

  task automatic do_read(input int v, input int e);
    @(posedge clk); #1;
    bus.rd_req = 1'b1;
    bus.rd_vertex = 5'(v);
    push_exp(K_READ, e, RL + 1, 0);
    @(negedge clk);
    chk("rd_ready_before", int'(bus.rd_ready), 1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rd_addr", int'(bus.predecessor_rd_addr), v);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on DONE entry and on rd_valid, and checks pass shape.
  initial begin
    int init_cyc = 0;
    int acc_cyc = 0;
    int bursts = 0;
    int run_len = 0;
    int gap_len = 0;
    bit prev_en = 1'b0;
    bit prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (clear) begin
        bursts = 0; run_len = 0; gap_len = 0;
        prev_en = 1'b0; prev_done = 1'b0;
      end else begin
        if (bus.dp_clear) begin
          init_cyc = cyc; bursts = 0; run_len = 0; gap_len = 0;
        end
        if (bus.dp_enable) begin
          chk("mux_while_enable", int'(bus.stg1_mux_control), 0);
          if (!prev_en) begin
            if (bursts > 0) chk("drain_gap", gap_len, PD);
            bursts++;
            run_len = 0;
          end
          run_len++;
          gap_len = 0;
        end else begin
          if (prev_en) chk("burst_len", run_len, EB);
          if (bus.busy && !bus.dp_clear) gap_len++;
        end
        if (bus.rd_valid) begin
          if (sbq.size() == 0 || sbq[0].kind != K_READ) begin
            unexpected("rd_valid");
          end else begin
            e = sbq.pop_front();
            chk("rd_pred", int'(bus.rd_pred), e.a);
            chk("rd_latency", cyc - acc_cyc, e.b);
          end
        end
        if (bus.rd_req && bus.rd_ready) acc_cyc = cyc;
        if (bus.done && !prev_done) begin
          if (sbq.size() == 0 || sbq[0].kind != K_DONE) begin
            unexpected("done_rise");
          end else begin
            e = sbq.pop_front();
            chk("iter_count_at_done", int'(bus.iter_count), e.a);
            chk("run_latency", cyc - init_cyc, e.b);
            chk("burst_count", bursts, e.c);
            chk("final_drain", gap_len, PD);
          end
        end
        prev_en = bus.dp_enable;
        prev_done = bus.done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.src_vertex = '0;
    bus.rd_req = 1'b0;
    bus.rd_vertex = '0;

    @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    @(posedge clk); #1;
    clear = 1'b0;

    // Run interrupted by clear at iteration 2, beat 3.
    bus.start = 1'b1;
    bus.src_vertex = 5'd11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("init_dp_clear", int'(bus.dp_clear), 1);
    repeat (16) @(negedge clk);
    chk("iter2_beat3_enable", int'(bus.dp_enable), 1);
    chk("iter2_count", int'(bus.iter_count), 1);
    clear = 1'b1;
    #1;
    chk("async_clear_outputs", out_vec(), 0);
    @(negedge clk);
    @(posedge clk); #1;
    clear = 1'b0;

    // Full run from vertex 5 with a stray start/rd_req during DRAIN.
    bus.start = 1'b1;
    bus.src_vertex = 5'd5;
    push_exp(K_DONE, 31, 373, 31);
    @(negedge clk);
    chk("idle_no_clear_yet", int'(bus.dp_clear), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("dp_clear_after_start", int'(bus.dp_clear), 1);
    chk("source_address", int'(bus.source_address), 5);
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.src_vertex = 5'd7;
    bus.rd_req = 1'b1;
    bus.rd_vertex = 5'd3;
    @(negedge clk);
    chk("drain_enable_low", int'(bus.dp_enable), 0);
    chk("rd_ready_outside_done", int'(bus.rd_ready), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rd_req = 1'b0;
    wait_done(450);
    chk("source_kept", int'(bus.source_address), 5);
    chk("mux_in_done", int'(bus.stg1_mux_control), 1);
    chk("busy_in_done", int'(bus.busy), 0);

    // Read of vertex 9 with a second request while it is outstanding.
    @(posedge clk); #1;
    bus.rd_req = 1'b1;
    bus.rd_vertex = 5'd9;
    push_exp(K_READ, 2, RL + 1, 0);
    @(negedge clk);
    chk("rd_ready_first", int'(bus.rd_ready), 1);
    @(posedge clk); #1;
    bus.rd_vertex = 5'd12;
    @(negedge clk);
    chk("rd_addr_9", int'(bus.predecessor_rd_addr), 9);
    chk("rd_ready_outstanding", int'(bus.rd_ready), 0);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rd_ready_returns", int'(bus.rd_ready), 1);
    repeat (2) @(negedge clk);

    do_read(0, 3);
    do_read(31, 28);
    do_read(20, 15);

    // start and rd_req together in DONE: start wins.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.src_vertex = 5'd5;
    bus.rd_req = 1'b1;
    bus.rd_vertex = 5'd4;
    zero_iter3 = 1'b1;
`ifdef BF_EARLY_EXIT_EN
    push_exp(K_DONE, 3, 37, 3);
`else
    push_exp(K_DONE, 31, 373, 31);
`endif
    @(negedge clk);
    chk("rd_ready_vs_start", int'(bus.rd_ready), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("restart_dp_clear", int'(bus.dp_clear), 1);
    chk("rd_addr_unchanged", int'(bus.predecessor_rd_addr), 20);
    wait_done(450);
    zero_iter3 = 1'b0;

    // start cancels an outstanding read.
    @(posedge clk); #1;
    bus.rd_req = 1'b1;
    bus.rd_vertex = 5'd9;
    @(negedge clk);
    chk("rd_ready_cancel_case", int'(bus.rd_ready), 1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    chk("rd_addr_cancel_case", int'(bus.predecessor_rd_addr), 9);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("cancel_dp_clear", int'(bus.dp_clear), 1);
    chk("cancel_no_valid", int'(bus.rd_valid), 0);
    repeat (6) @(negedge clk);

    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    chk("final_clear_outputs", out_vec(), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bellman_ford_sequencer.md
# bellman_ford_sequencer

Control FSM that drives the four-lane pipelined Bellman-Ford datapath through a full shortest-path run. It issues the datapath clear, gates the edge-reader enable for one pass over the edge list per iteration, and drains the 4-stage pipeline between iterations. It decides termination and then switches the stage-1 read mux to serve single-vertex predecessor readouts over a request/valid handshake. It sits directly above `pipelined_bellman_ford` and owns all of that module's control inputs.

## Interface
- `NUM_VERTICES`, default 32: vertex count; the address width is 5 bits, so the value must be ≤ 32.
- `EDGE_BEATS`, default 8: edge-reader beats per pass, at 4 edges per beat.
- `PIPE_DEPTH`, default 4: drain cycles from the last enabled beat until the final stage-4 write lands.
- `READ_LAT`, default 1: cycles from `predecessor_rd_addr` change to a valid `predecessor_out`.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `clear`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse that begins a run; sampled in IDLE and DONE only.
- `src_vertex`  in  5  source vertex, captured on an accepted `start`.
- `relax_wr`  in  4  the stage-4 write enables (lanes A..D) from the datapath.
- `dp_clear`  out  1  datapath clear.
- `dp_enable`  out  1  edge-reader enable.
- `stg1_mux_control`  out  1  selects `predecessor_rd_addr` on lane A.
- `source_address`  out  5  registered copy of `src_vertex`.
- `predecessor_rd_addr`  out  5  readout address.
- `predecessor_in`  in  5  the datapath's `predecessor_out`.
- `busy`  out  1  high from an accepted start until DONE is reached.
- `done`  out  1  high while in DONE.
- `iter_count`  out  5  number of completed iterations.
- `rd_req`, `rd_vertex[4:0]`  in  readout request.
- `rd_ready`  out  1  readout request can be accepted.
- `rd_valid`  out  1  one-cycle strobe marking `rd_pred` valid.
- `rd_pred`  out  5  predecessor of the requested vertex.

## Operation
- States: IDLE → INIT → ITER → DRAIN → (ITER | DONE).
- IDLE: all outputs are 0. `start` captures `src_vertex` into `source_address` and moves to INIT.
- INIT: exactly 1 cycle. `dp_clear`=1 and `iter_count`←0. Next state is ITER.
- ITER: `dp_enable`=1 for exactly `EDGE_BEATS` consecutive cycles, counted by a beat counter running 0..EDGE_BEATS-1. The edge reader wraps on its own after that many beats. After the last beat, go to DRAIN.
- DRAIN: `dp_enable`=0 for exactly `PIPE_DEPTH` cycles. On the last DRAIN cycle, `iter_count` increments.
  - If the incremented value equals `NUM_VERTICES-1`, go to DONE.
  - Otherwise go to ITER.
- DONE: `done`=1, `busy`=0, `stg1_mux_control`=1, `rd_ready`=1 when no read is outstanding.
  - `rd_req`&&`rd_ready` registers `rd_vertex` onto `predecessor_rd_addr` and drops `rd_ready`.
  - `READ_LAT` cycles later, `rd_pred`←`predecessor_in` and `rd_valid` pulses for 1 cycle. `rd_ready` returns to 1 in the same cycle.
  - At most one read is outstanding.
- `start` in DONE returns to INIT and cancels any outstanding read; `rd_valid` is not issued for it.
- `start` in INIT, ITER or DRAIN is ignored.
- `rd_req` outside DONE is ignored.
- `iter_count` width is 5 bits. It saturates at `NUM_VERTICES-1` and never wraps.

## Timing
- Reset values: every output is 0, including `source_address` and `predecessor_rd_addr`. The FSM is in IDLE.
- An asynchronous `clear` in any state forces IDLE immediately. Any run or read in progress is abandoned.
- `start` at cycle t gives INIT (`dp_clear`=1) at t+1. The first `dp_enable` is at t+2.
- Each iteration lasts `EDGE_BEATS+PIPE_DEPTH` cycles. The default full run is 1+31×12 = 373 cycles from INIT to DONE entry.
- `stg1_mux_control` rises on the first DONE cycle and stays 0 whenever `dp_enable` can be 1.
- Readout latency is `READ_LAT`+1 cycles from request acceptance to `rd_valid`.

## Configuration
- `BF_EARLY_EXIT_EN` defined:
  - A sticky flag ORs `|relax_wr` over every ITER and DRAIN cycle of the current iteration.
  - On the last DRAIN cycle, if the flag is 0, the FSM goes to DONE regardless of `iter_count`.
  - The flag clears on entry to ITER.
- `BF_EARLY_EXIT_EN` undefined: `relax_wr` is ignored, and the run always executes exactly `NUM_VERTICES-1` iterations.

## Structure
- Shared package `bf_pkg`: the state enum (IDLE, INIT, ITER, DRAIN, DONE), `VADDR_W`=5, and `LANES`=4.
- One natural sub-module, `bf_readout_port`: the readout handshake and the `READ_LAT` delay line, enabled by a DONE-state qualifier from the FSM.

## Test plan
- Reset in the middle of ITER (beat 3 of iteration 2) → next edge: all outputs 0 and the FSM is in IDLE. A subsequent `start` gives `dp_clear` one cycle later.
- `start` with `src_vertex`=5 and defaults, `relax_wr` held at 4'hF:
  - `source_address`=5.
  - `dp_enable` high in 31 bursts of 8 cycles, separated by 4-cycle gaps.
  - `done` rises 373 cycles after INIT, with `iter_count`=31.
- With `BF_EARLY_EXIT_EN`, `relax_wr`=0 throughout iteration 3 → DONE is reached after that iteration's DRAIN, with `iter_count`=3. Without the macro, the run still takes 31 iterations.
- In DONE, `rd_req` with `rd_vertex`=9 while the model returns `predecessor_in`=2 → `predecessor_rd_addr`=9 the next cycle, then `rd_valid`=1 with `rd_pred`=2 at acceptance+2. A second `rd_req` while the first is outstanding is not accepted (`rd_ready`=0).
- `start` asserted during DRAIN → ignored, with iteration timing unchanged. `start` asserted in DONE during an outstanding read → INIT next cycle and no `rd_valid` is issued.
- `start` and `rd_req` asserted in the same DONE cycle → `start` wins: INIT follows, and the read is not accepted.
